// File: rtl/mul_seq_pkg.sv
// Shared definitions for the nibble-serial 8x8 multiplier: the FSM state set
// (IDLE, MUL, DONE) and the nibble geometry.
package mul_seq_pkg;

    localparam int unsigned NIB_W = 4;
    localparam int unsigned STEPS = 4;

    // FSM state set, kept as plain constants for legacy tool compatibility
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t MUL  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Select the low (hi=0) or high (hi=1) nibble of a byte
    function automatic logic [NIB_W-1:0] nibble(input logic [7:0] v, input logic hi);
        return hi ? v[7:4] : v[3:0];
    endfunction

endpackage

// File: rtl/mul4x4_array.sv
// Combinational 4x4 unsigned array multiplier: sum of AND-gated, shifted
// copies of the multiplicand, one row per multiplier bit.
module mul4x4_array
    import mul_seq_pkg::*;
(
    input  logic [NIB_W-1:0]   a_i,
    input  logic [NIB_W-1:0]   b_i,
    output logic [2*NIB_W-1:0] p_o
);

    // Accumulate one partial-product row per multiplier bit
    always_comb begin
        p_o = '0;
        for (int i = 0; i < NIB_W; i++) begin
            p_o = p_o + (({{NIB_W{1'b0}}, a_i} << i) & {(2*NIB_W){b_i[i]}});
        end
    end

endmodule

// File: rtl/mul8_nibble_seq.sv
// Sequential 8x8 unsigned multiplier that reuses one 4x4 array multiplier over
// four cycles (one nibble pair per cycle), with valid/ready handshakes.
// Optional feature: define MAC_ACCUM_EN to add an ACC_W-bit product
// accumulator; otherwise acc_out is tied to 0 and acc_clr is unused.
module mul8_nibble_seq
    import mul_seq_pkg::*;
#(
    parameter int unsigned ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_p,
    output logic             busy,
    input  logic             acc_clr,
    output logic [ACC_W-1:0] acc_out
);

    localparam logic [1:0] LastStep = 2'(STEPS - 1);

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] sum_q, sum_d;
    logic [1:0]  step_q, step_d;

    logic [NIB_W-1:0]   nib_a, nib_b;
    logic [2*NIB_W-1:0] pp;
    logic [3:0]         shamt;
    logic [15:0]        pp_shifted;

    // Pick the nibble pair and weight for the current step
    always_comb begin
        nib_a = nibble(a_q, step_q[0]);
        nib_b = nibble(b_q, step_q[1]);
        shamt = 4'(NIB_W) * 4'({1'b0, step_q[0]} + {1'b0, step_q[1]});
        pp_shifted = {8'h00, pp} << shamt;
    end

    mul4x4_array u_mul4x4_array (
        .a_i (nib_a),
        .b_i (nib_b),
        .p_o (pp)
    );

    // FSM and datapath next state
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    sum_d   = '0;
                    step_d  = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                // Product of two bytes fits in 16 bits, so no carry-out is needed
                sum_d  = sum_q + pp_shifted;
                step_d = step_q + 2'd1;
                if (step_q == LastStep) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            step_q  <= step_d;
        end
    end

    // Handshake and status outputs; the result is masked unless presented
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
        out_p     = out_valid ? sum_q : 16'h0000;
    end

`ifdef MAC_ACCUM_EN
    logic [ACC_W-1:0] acc_q, acc_d;

    // Clear only in IDLE (wins over a coincident accept); add on MUL->DONE
    always_comb begin
        acc_d = acc_q;
        if (state_q == IDLE && acc_clr) begin
            acc_d = '0;
        end else if (state_q == MUL && step_q == LastStep) begin
            acc_d = acc_q + ACC_W'(sum_d);
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_out = acc_q;
`else
    logic unused_acc_clr;
    assign unused_acc_clr = acc_clr;
    assign acc_out        = '0;
`endif

endmodule

// File: tb/tb_mul8_nibble_seq.sv
// Self-checking bench for mul8_nibble_seq: a transaction-level model is
// compared against the DUT every cycle, plus directed literal checks.
module tb_mul8_nibble_seq;

    localparam int unsigned ACC_W = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_p;
    logic             busy;
    logic             acc_clr;
    logic [ACC_W-1:0] acc_out;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    always #5 clk = ~clk;

    mul8_nibble_seq #(
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy),
        .acc_clr   (acc_clr),
        .acc_out   (acc_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Transaction model: an op is pending from accept until its result is
    // taken; the product appears 4 edges after the accept.
    bit               model_live = 1'b0;
    bit               m_busy = 1'b0;
    bit               m_valid = 1'b0;
    int               m_edges = 0;
    logic [15:0]      m_prod = '0;
    logic [ACC_W-1:0] m_acc = '0;

    always @(posedge clk) begin
        cycle++;
        if (rst) begin
            model_live = 1'b1;
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_edges = 0;
            m_prod  = '0;
            m_acc   = '0;
        end else if (!m_busy) begin
`ifdef MAC_ACCUM_EN
            if (acc_clr) m_acc = '0;
`endif
            if (in_valid) begin
                m_busy  = 1'b1;
                m_edges = 0;
                m_prod  = 16'(in_a) * 16'(in_b);
            end
        end else if (!m_valid) begin
            m_edges++;
            if (m_edges == 4) begin
                m_valid = 1'b1;
`ifdef MAC_ACCUM_EN
                m_acc = m_acc + ACC_W'(m_prod);
`endif
            end
        end else if (out_ready) begin
            m_valid = 1'b0;
            m_busy  = 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (model_live) begin
            check("in_ready", 32'(in_ready), 32'(!m_busy));
            check("busy", 32'(busy), 32'(m_busy));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("out_p", 32'(out_p), m_valid ? 32'(m_prod) : 32'd0);
            check("acc_out", 32'(acc_out), 32'(m_acc));
        end
    end

    // Record DUT accept cycles for the spacing test
    bit record = 1'b0;
    int accept_cycles[$];
    always @(posedge clk) begin
        if (record && !rst && in_valid && in_ready) accept_cycles.push_back(cycle);
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic clr,
                          input logic [15:0] exp, input string name);
        int n;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        acc_clr = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_clr = 1'b0;
        in_a = ~a;          // operand changes while busy must be ignored
        in_b = ~b;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                n = i;
                break;
            end
        end
        check({name, " latency"}, 32'(n), 32'd4);
        check({name, " product"}, 32'(out_p), 32'(exp));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, " drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b0;
        acc_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_p", 32'(out_p), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset acc_out", 32'(acc_out), 32'd0);

        // Basic products
        run_op(8'h12, 8'h34, 1'b0, 16'h03A8, "12x34");
        check("model 12x34", 32'(m_prod), 32'h03A8);
        run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, "FFxFF");
        check("model FFxFF", 32'(m_prod), 32'hFE01);
        run_op(8'h00, 8'hAB, 1'b0, 16'h0000, "00xAB");
        run_op(8'h0F, 8'hF0, 1'b0, 16'h0E10, "0FxF0");
        run_op(8'hA5, 8'h5A, 1'b0, 16'h3A02, "A5x5A");

        // Output stall: result held, no accept of a second pulse
        in_a = 8'h12;
        in_b = 8'h34;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        check("stall valid seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                in_valid = 1'b1;
                in_a = 8'h77;
                in_b = 8'h99;
            end
            if (i == 5) in_valid = 1'b0;
            @(posedge clk);
            #1;
            check("stall out_p", 32'(out_p), 32'h03A8);
            check("stall in_ready", 32'(in_ready), 32'd0);
            check("stall out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post-stall in_ready", 32'(in_ready), 32'd1);
        check("post-stall out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("second pulse ignored", 32'(busy), 32'd0);

        // Reset during step2 aborts the op
        in_a = 8'hC3;
        in_b = 8'h3C;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("abort no result", 32'(out_valid), 32'd0);
        end

        // Back-to-back with out_ready tied high: accepts 6 cycles apart
        accept_cycles.delete();
        record = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        repeat (26) begin
            @(posedge clk);
            #1;
            in_a = 8'($urandom);
            in_b = 8'($urandom);
        end
        in_valid = 1'b0;
        record = 1'b0;
        for (int i = 0; i < 20 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        check("b2b accept count", 32'(accept_cycles.size() >= 4), 32'd1);
        for (int i = 1; i < accept_cycles.size(); i++) begin
            check("b2b spacing", 32'(accept_cycles[i] - accept_cycles[i-1]), 32'd6);
        end

`ifdef MAC_ACCUM_EN
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        check("acc cleared", 32'(acc_out), 32'd0);
        run_op(8'd3, 8'd4, 1'b0, 16'd12, "acc 3x4");
        check("acc after 3x4", 32'(acc_out), 32'd12);
        run_op(8'd5, 8'd6, 1'b0, 16'd30, "acc 5x6");
        check("acc after 5x6", 32'(acc_out), 32'd42);
        run_op(8'h10, 8'h10, 1'b0, 16'h0100, "acc 10x10");
        check("acc after 10x10", 32'(acc_out), 32'd298);
        run_op(8'd2, 8'd2, 1'b1, 16'd4, "acc clr+accept");
        check("acc clr priority", 32'(acc_out), 32'd4);
`else
        run_op(8'd3, 8'd4, 1'b1, 16'd12, "noacc 3x4");
        check("acc tied zero", 32'(acc_out), 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul8_nibble_seq.md
MUL8_NIBBLE_SEQ -- requirements
Module: mul8_nibble_seq

Interface
REQ-001 SHALL have parameter ACC_W, default 20, accumulator width in bits; only used when MAC_ACCUM_EN is defined.
REQ-002 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  reset; it is synchronous and active-high.
REQ-004 SHALL have port in_valid  in  1  operand pair offered.
REQ-005 SHALL have port in_ready  out  1  block can accept an operand pair.
REQ-006 SHALL have port in_a  in  8  unsigned multiplicand.
REQ-007 SHALL have port in_b  in  8  unsigned multiplier.
REQ-008 SHALL have port out_valid  out  1  result held on out_p.
REQ-009 SHALL have port out_ready  in  1  consumer takes the result.
REQ-010 SHALL have port out_p  out  16  unsigned product in_a*in_b.
REQ-011 SHALL have port busy  out  1  high in every state except IDLE.
REQ-012 SHALL have port acc_clr  in  1  accumulator clear request.
REQ-013 SHALL have port acc_out  out  ACC_W  running accumulator value.

Function
REQ-014 SHALL run a three-state FSM: IDLE, MUL, DONE.
REQ-015 SHALL drive in_ready high only in IDLE; an accept occurs on an edge where in_valid and in_ready are both high.
REQ-016 SHALL latch in_a and in_b on accept, clear the 16-bit partial sum and the 2-bit step counter, and go to MUL.
REQ-017 SHALL, in MUL, multiply one nibble pair per cycle through a single shared 4x4 multiplier, in this order: step0 a[3:0]*b[3:0] shifted 0; step1 a[7:4]*b[3:0] shifted 4; step2 a[3:0]*b[7:4] shifted 4; step3 a[7:4]*b[7:4] shifted 8.
REQ-018 SHALL add each shifted partial product into the 16-bit partial sum; the sum never overflows, so no carry-out is kept.
REQ-019 SHALL move from MUL to DONE on the edge that adds step3, so out_valid rises after the 4th rising edge following the accept.
REQ-020 SHALL, in DONE, hold out_valid high and out_p stable until out_ready is high, then return to IDLE on that edge.
REQ-021 SHALL NOT accept new operands in the cycle of an output handshake; in_ready rises the cycle after, giving a minimum spacing of 6 cycles per operation.
REQ-022 SHALL ignore in_valid and operand changes while busy; latched operands are unaffected.
REQ-023 SHALL stall in DONE indefinitely while out_ready is low; there is no timeout.
REQ-024 SHALL drive out_p to 0 whenever out_valid is low.

Reset
REQ-025 SHALL, when rst is high at a rising edge, enter IDLE, clear operands, partial sum, step counter and accumulator, and drive out_valid=0, out_p=0, busy=0, in_ready=1 and acc_out=0.
REQ-026 SHALL, when rst is high mid-operation (MUL or DONE), abort the operation with no result ever presented; rst takes priority over every other input.

Configuration
REQ-027 SHALL, with macro MAC_ACCUM_EN defined, add the final 16-bit product, zero-extended, into an ACC_W-bit accumulator on the MUL-to-DONE edge, wrapping modulo 2^ACC_W.
REQ-028 SHALL, with MAC_ACCUM_EN defined, clear the accumulator when acc_clr is high in IDLE; acc_clr is ignored in MUL and DONE.
REQ-029 SHALL, with MAC_ACCUM_EN defined, give acc_clr priority when it coincides with an accept, so the accepted product accumulates from 0.
REQ-030 SHALL, with MAC_ACCUM_EN defined, update acc_out continuously from the accumulator register.
REQ-031 SHALL, without MAC_ACCUM_EN, tie acc_out to 0, leave acc_clr unused and instantiate no accumulator register.

Structure
REQ-032 SHALL take from shared package mul_seq_pkg the FSM state enum (IDLE, MUL, DONE) and the constants NIB_W=4 and STEPS=4.
REQ-033 SHALL instantiate exactly one sub-module, mul4x4_array: a combinational 4-bit x 4-bit unsigned array multiplier with an 8-bit product.

Verification
REQ-034 SHALL cover: reset, then accept 0x12*0x34 -> out_valid after 4 edges, out_p=0x03A8.
REQ-035 SHALL cover: 0xFF*0xFF -> out_p=0xFE01; 0x00*0xAB -> out_p=0x0000.
REQ-036 SHALL cover: out_ready held low for 10 cycles after out_valid -> out_p stable, in_ready=0, a second in_valid pulse is not accepted.
REQ-037 SHALL cover: rst pulsed during step2 -> out_valid stays 0, in_ready=1 on the next cycle, no result is produced.
REQ-038 SHALL cover: out_ready tied high with in_valid held high -> accepts exactly 6 cycles apart.
REQ-039 SHALL cover, with MAC_ACCUM_EN: acc_clr, then 3*4, 5*6, 0x10*0x10 -> acc_out = 12, 42, 298 in turn.
